// File: rtl/axi_lite_regex_regfile_pkg.sv
// Shared constants and helpers for the regex coprocessor host register bank.
package axi_lite_regex_regfile_pkg;

   localparam int REG_WIDTH  = 32;
   localparam int STRB_WIDTH = REG_WIDTH / 8;

   // Command codes understood by the downstream regex control block
   localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'd0;
   localparam logic [REG_WIDTH-1:0] CMD_START = 32'd1;
   localparam logic [REG_WIDTH-1:0] CMD_RESET = 32'd2;

   // Status codes reported back by the downstream regex control block
   localparam logic [REG_WIDTH-1:0] STATUS_IDLE    = 32'd0;
   localparam logic [REG_WIDTH-1:0] STATUS_RUNNING = 32'd1;
   localparam logic [REG_WIDTH-1:0] STATUS_ACCEPT  = 32'd2;
   localparam logic [REG_WIDTH-1:0] STATUS_ERROR   = 32'd3;

   // Register word indices (byte offset >> 2)
   localparam logic [2:0] REG_OFF_DATA_IN  = 3'd0;
   localparam logic [2:0] REG_OFF_ADDRESS  = 3'd1;
   localparam logic [2:0] REG_OFF_START_CC = 3'd2;
   localparam logic [2:0] REG_OFF_END_CC   = 3'd3;
   localparam logic [2:0] REG_OFF_CMD      = 3'd4;
   localparam logic [2:0] REG_OFF_STATUS   = 3'd5;
   localparam logic [2:0] REG_OFF_DATA_O   = 3'd6;

   localparam int NUM_RW_REGS = 5;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // Keep each old byte unless its strobe selects the new byte
   function automatic logic [REG_WIDTH-1:0] byte_merge(
      input logic [REG_WIDTH-1:0]  old_val,
      input logic [REG_WIDTH-1:0]  new_val,
      input logic [STRB_WIDTH-1:0] strb
   );
      logic [REG_WIDTH-1:0] merged;
      merged = old_val;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (strb[i]) merged[i*8 +: 8] = new_val[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_lite_regex_regfile.sv
// AXI4-Lite slave register bank feeding the regex coprocessor control block.
// One-entry AW and W holding buffers, one outstanding write response and
// one outstanding read; all AXI outputs except the readies come from flops.
module axi_lite_regex_regfile
   import axi_lite_regex_regfile_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [REG_WIDTH-1:0]      s_axi_wdata,
   input  logic [STRB_WIDTH-1:0]     s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [REG_WIDTH-1:0]      s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic [REG_WIDTH-1:0]      data_in_register,
   output logic [REG_WIDTH-1:0]      address_register,
   output logic [REG_WIDTH-1:0]      start_cc_pointer_register,
   output logic [REG_WIDTH-1:0]      end_cc_pointer_register,
   output logic [REG_WIDTH-1:0]      cmd_register,
   input  logic [REG_WIDTH-1:0]      status_register,
   input  logic [REG_WIDTH-1:0]      data_o_register
);

   logic                  aw_full_q, aw_full_d;
   logic [2:0]            aw_idx_q, aw_idx_d;
   logic                  w_full_q, w_full_d;
   logic [REG_WIDTH-1:0]  w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [REG_WIDTH-1:0]  rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [REG_WIDTH-1:0]  regs_q [NUM_RW_REGS];
   logic [REG_WIDTH-1:0]  regs_d [NUM_RW_REGS];

   logic aw_hs, w_hs, ar_hs, commit;
   logic [2:0] ar_idx;

   // Only word-select bits [4:2] are decoded; the rest are deliberately ignored
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

   assign s_axi_awready = !aw_full_q;
   assign s_axi_wready  = !w_full_q;
   assign s_axi_arready = !rvalid_q;

   assign aw_hs  = s_axi_awvalid && !aw_full_q;
   assign w_hs   = s_axi_wvalid && !w_full_q;
   assign ar_hs  = s_axi_arvalid && !rvalid_q;
   assign ar_idx = s_axi_araddr[4:2];
   // A pending response blocks the next commit, bready cycle included
   assign commit = aw_full_q && w_full_q && !bvalid_q;

   // Write path: buffer AW/W independently, commit when both are held
   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;

      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         if (aw_idx_q <= REG_OFF_CMD) begin
            regs_d[aw_idx_q] = byte_merge(regs_q[aw_idx_q], w_data_q, w_strb_q);
            bresp_d          = AXI_RESP_OKAY;
         end else begin
            bresp_d = AXI_RESP_SLVERR;
         end
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
      end

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = s_axi_awaddr[4:2];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = s_axi_wdata;
         w_strb_d = s_axi_wstrb;
      end
   end

   // Read path: capture pre-commit register contents at the AR handshake
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = AXI_RESP_OKAY;
         case (ar_idx)
            REG_OFF_DATA_IN:  rdata_d = regs_q[REG_OFF_DATA_IN];
            REG_OFF_ADDRESS:  rdata_d = regs_q[REG_OFF_ADDRESS];
            REG_OFF_START_CC: rdata_d = regs_q[REG_OFF_START_CC];
            REG_OFF_END_CC:   rdata_d = regs_q[REG_OFF_END_CC];
            REG_OFF_CMD:      rdata_d = regs_q[REG_OFF_CMD];
            REG_OFF_STATUS:   rdata_d = status_register;
            REG_OFF_DATA_O:   rdata_d = data_o_register;
            default: begin
               rdata_d = '0;
               rresp_d = AXI_RESP_SLVERR;
            end
         endcase
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   // State registers; reset drops buffered beats and pending responses
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= AXI_RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= AXI_RESP_OKAY;
         for (int i = 0; i < NUM_RW_REGS; i++) regs_q[i] <= '0;
         regs_q[REG_OFF_CMD] <= CMD_NOP;
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
      end
   end

   assign s_axi_bvalid = bvalid_q;
   assign s_axi_bresp  = bresp_q;
   assign s_axi_rvalid = rvalid_q;
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;

   assign data_in_register          = regs_q[REG_OFF_DATA_IN];
   assign address_register          = regs_q[REG_OFF_ADDRESS];
   assign start_cc_pointer_register = regs_q[REG_OFF_START_CC];
   assign end_cc_pointer_register   = regs_q[REG_OFF_END_CC];
   assign cmd_register              = regs_q[REG_OFF_CMD];

endmodule

// File: tb/tb_axi_lite_regex_regfile.sv
// Scoreboard bench for the regex host register bank: drivers push expected
// B/R responses computed from a plain array model, a monitor pops them.
module tb_axi_lite_regex_regfile;
   import axi_lite_regex_regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [4:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [31:0] data_in_register, address_register, start_cc_pointer_register;
   logic [31:0] end_cc_pointer_register, cmd_register;
   logic [31:0] status_register, data_o_register;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rsp_t;

   rsp_t        rq[$];
   logic [1:0]  bq[$];
   logic [31:0] model [5];
   int vectors = 0;
   int miscompares = 0;
   rsp_t       mon_r;
   logic [1:0] mon_b;

   always #5 clk = ~clk;

   axi_lite_regex_regfile #(.AXI_ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready),
      .data_in_register(data_in_register), .address_register(address_register),
      .start_cc_pointer_register(start_cc_pointer_register),
      .end_cc_pointer_register(end_cc_pointer_register), .cmd_register(cmd_register),
      .status_register(status_register), .data_o_register(data_o_register)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // Monitor: every completed B or R handshake is compared with the queue head
   always @(negedge clk) begin
      if (!rst) begin
         if (s_axi_bvalid && s_axi_bready) begin
            if (bq.size() == 0) begin
               check("b_unexpected", 32'd1, 32'd0);
            end else begin
               mon_b = bq.pop_front();
               check("bresp", {30'd0, s_axi_bresp}, {30'd0, mon_b});
            end
         end
         if (s_axi_rvalid && s_axi_rready) begin
            if (rq.size() == 0) begin
               check("r_unexpected", 32'd1, 32'd0);
            end else begin
               mon_r = rq.pop_front();
               check("rdata", s_axi_rdata, mon_r.data);
               check("rresp", {30'd0, s_axi_rresp}, {30'd0, mon_r.resp});
            end
         end
      end
   end

   // Reference model: word index picks a register; RO/unmapped writes are errors
   task automatic exp_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      idx = int'(addr[4:2]);
      if (idx < 5) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
         bq.push_back(2'b00);
      end else begin
         bq.push_back(2'b10);
      end
   endtask

   task automatic exp_read(input logic [4:0] addr);
      rsp_t r;
      int idx;
      idx = int'(addr[4:2]);
      r.resp = 2'b00;
      if (idx < 5)       r.data = model[idx];
      else if (idx == 5) r.data = status_register;
      else if (idx == 6) r.data = data_o_register;
      else begin
         r.data = 32'd0;
         r.resp = 2'b10;
      end
      rq.push_back(r);
   endtask

   // Drivers: all are entered and left just after a rising edge
   task automatic send_aw(input logic [4:0] addr);
      int n = 0;
      s_axi_awaddr  = addr;
      s_axi_awvalid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!s_axi_awready && n < 100);
      if (!s_axi_awready) timeout("aw_handshake");
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      s_axi_wvalid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!s_axi_wready && n < 100);
      if (!s_axi_wready) timeout("w_handshake");
      @(posedge clk); #1;
      s_axi_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [4:0] addr);
      int n = 0;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!s_axi_arready && n < 100);
      if (!s_axi_arready) timeout("ar_handshake");
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
   endtask

   task automatic take_b(input int delay);
      int n = 0;
      while (!s_axi_bvalid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_axi_bvalid) begin
         timeout("bvalid_wait");
         return;
      end
      @(posedge clk); #1;
      repeat (delay) begin
         @(posedge clk); #1;
      end
      s_axi_bready = 1'b1;
      @(posedge clk); #1;
      s_axi_bready = 1'b0;
   endtask

   task automatic take_r(input int delay);
      int n = 0;
      while (!s_axi_rvalid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_axi_rvalid) begin
         timeout("rvalid_wait");
         return;
      end
      @(posedge clk); #1;
      repeat (delay) begin
         @(posedge clk); #1;
      end
      s_axi_rready = 1'b1;
      @(posedge clk); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic check_regs();
      check("data_in_register", data_in_register, model[0]);
      check("address_register", address_register, model[1]);
      check("start_cc_register", start_cc_pointer_register, model[2]);
      check("end_cc_register", end_cc_pointer_register, model[3]);
      check("cmd_register", cmd_register, model[4]);
   endtask

   // order: 0 = AW and W together, 1 = AW first, 2 = W first
   task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, input int gap, input int bdelay);
      exp_write(addr, data, strb);
      if (order == 0) begin
         fork
            send_aw(addr);
            send_w(data, strb);
         join
      end else if (order == 1) begin
         send_aw(addr);
         repeat (gap) begin @(posedge clk); #1; end
         send_w(data, strb);
      end else begin
         send_w(data, strb);
         repeat (gap) begin @(posedge clk); #1; end
         send_aw(addr);
      end
      take_b(bdelay);
      check_regs();
   endtask

   task automatic do_read(input logic [4:0] addr, input int rdelay);
      exp_read(addr);
      send_ar(addr);
      take_r(rdelay);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_arvalid = 1'b0;
      s_axi_bready  = 1'b0;
      s_axi_rready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bq.delete();
      rq.delete();
      for (int i = 0; i < 5; i++) model[i] = 32'd0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] first_val;
      s_axi_awaddr = '0;
      s_axi_wdata  = '0;
      s_axi_wstrb  = '0;
      s_axi_araddr = '0;
      status_register = STATUS_IDLE;
      data_o_register = 32'd0;
      apply_reset();

      // Reset state
      @(negedge clk);
      check("rst_awready", {31'd0, s_axi_awready}, 32'd1);
      check("rst_wready",  {31'd0, s_axi_wready},  32'd1);
      check("rst_arready", {31'd0, s_axi_arready}, 32'd1);
      check("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
      check("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
      check("rst_rdata",   s_axi_rdata, 32'd0);
      check_regs();
      @(posedge clk); #1;
      do_read(5'h10, 0);
      do_read(5'h00, 1);

      // AW two cycles ahead of W
      do_write(5'h04, 32'hDEADBEEF, 4'hF, 1, 1, 0);
      check("addr_reg_deadbeef", address_register, 32'hDEADBEEF);
      do_read(5'h04, 0);

      // Partial strobe merge
      do_write(5'h00, 32'h11223344, 4'hF, 2, 0, 0);
      do_write(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 1);
      check("partial_strobe", data_in_register, 32'h11BB33DD);

      // Read-only and unmapped targets
      do_write(5'h14, 32'h12345678, 4'hF, 0, 0, 0);
      do_write(5'h1C, 32'h0000FFFF, 4'hF, 1, 0, 0);
      do_read(5'h1C, 0);
      status_register = STATUS_ERROR;
      do_read(5'h14, 2);
      data_o_register = 32'hC0FFEE01;
      do_read(5'h18, 0);

      // Backpressure: second pair buffers behind an unacknowledged response
      first_val = 32'hA5A5_0001;
      exp_write(5'h0C, first_val, 4'hF);
      fork
         send_aw(5'h0C);
         send_w(first_val, 4'hF);
      join
      begin
         int n = 0;
         while (!s_axi_bvalid && n < 100) begin @(negedge clk); n++; end
         if (!s_axi_bvalid) timeout("bp_first_bvalid");
      end
      @(posedge clk); #1;
      exp_write(5'h0C, 32'h5A5A_0002, 4'b1100);
      fork
         send_aw(5'h0D);
         send_w(32'h5A5A_0002, 4'b1100);
      join
      @(negedge clk);
      check("bp_awready_low", {31'd0, s_axi_awready}, 32'd0);
      check("bp_wready_low",  {31'd0, s_axi_wready},  32'd0);
      check("bp_hold_first",  end_cc_pointer_register, first_val);
      repeat (3) @(negedge clk);
      check("bp_bvalid_held", {31'd0, s_axi_bvalid}, 32'd1);
      check("bp_no_commit",   end_cc_pointer_register, first_val);
      @(posedge clk); #1;
      take_b(0);
      take_b(0);
      check("bp_second_applied", end_cc_pointer_register, 32'h5A5A_0001);
      check_regs();

      // Reset after AW only: the buffered address is lost
      send_aw(5'h00);
      apply_reset();
      send_w(32'h5A5A5A5A, 4'hF);
      repeat (4) @(negedge clk);
      check("rstmid_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
      check("rstmid_data_in", data_in_register, 32'd0);
      check("rstmid_wready", {31'd0, s_axi_wready}, 32'd0);
      @(posedge clk); #1;
      exp_write(5'h08, 32'h5A5A5A5A, 4'hF);
      send_aw(5'h08);
      take_b(0);
      check_regs();

      // Command register persists; concurrent read sees the pre-write value
      do_write(5'h10, CMD_RESET, 4'hF, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      check("cmd_reset_held", cmd_register, CMD_RESET);
      exp_read(5'h10);
      exp_write(5'h10, CMD_START, 4'hF);
      fork
         send_aw(5'h10);
         send_w(CMD_START, 4'hF);
      join
      send_ar(5'h12);
      fork
         take_b(0);
         take_r(1);
      join
      check("cmd_start_after", cmd_register, CMD_START);
      check_regs();

      // Randomized traffic
      for (int it = 0; it < 200; it++) begin
         logic [4:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         a = 5'($urandom_range(0, 31));
         d = $urandom();
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) status_register = $urandom();
         if ($urandom_range(0, 3) == 0) data_o_register = $urandom();
         if ($urandom_range(0, 9) < 6)
            do_write(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
         else
            do_read(a, int'($urandom_range(0, 3)));
      end

      repeat (4) @(posedge clk);
      #1;
      check("bq_drained", bq.size(), 32'd0);
      check("rq_drained", rq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_lite_regex_regfile.md
Name: axi_lite_regex_regfile

Overview:
AXI4-Lite slave register bank that sits directly upstream of the regex coprocessor control block. It turns host AXI4-Lite transactions into the control-block register inputs: data_in_register, address_register, start_cc_pointer_register, end_cc_pointer_register and cmd_register. It returns status_register and data_o_register to the host over the read channel. Handshaking is fully registered, with one outstanding read and one outstanding write.

Parameters:
AXI_ADDR_WIDTH, 5, byte-address width of the AXI port; only bits [4:2] are decoded.
REG_WIDTH, package constant (32), data width of the AXI bus and of every register. Not overridable here.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  REG_WIDTH  write data
s_axi_wstrb  in  REG_WIDTH/8  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  AXI_ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  REG_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
data_in_register  out  REG_WIDTH  register at offset 0x00, RW
address_register  out  REG_WIDTH  register at offset 0x04, RW
start_cc_pointer_register  out  REG_WIDTH  register at offset 0x08, RW
end_cc_pointer_register  out  REG_WIDTH  register at offset 0x0C, RW
cmd_register  out  REG_WIDTH  register at offset 0x10, RW
status_register  in  REG_WIDTH  read at offset 0x14, RO
data_o_register  in  REG_WIDTH  read at offset 0x18, RO

Behaviour:
- Reset (rst=1 at posedge):
  - Register outputs: all RW registers go to 0; cmd_register goes to CMD_NOP (0).
  - Handshake outputs: awready=wready=arready=1 (derived from empty buffers); bvalid=rvalid=0; bresp=rresp=0; rdata=0.
  - Reset mid-transaction drops any buffered address or data and any pending response; nothing is committed.
- Write channel:
  - AW and W are independent, each with a one-entry holding buffer. awready = !aw_full, wready = !w_full.
  - A handshake on a channel fills that channel's buffer at the edge.
  - Commit edge: aw_full && w_full && !bvalid. At that edge:
    - the target register is updated by byte-merge: byte i is taken from wdata where wstrb[i]=1, otherwise the old byte is kept;
    - both buffers clear;
    - bvalid rises.
  - bresp = OKAY (2'b00) for offsets 0x00–0x10.
  - bresp = SLVERR (2'b10) for offsets 0x14, 0x18 and 0x1C. No state changes on an SLVERR write.
  - bvalid holds until bvalid && bready, then drops at the next edge.
  - A new commit cannot occur in the same cycle that bvalid is high (the bready cycle included).
  - AW and W may arrive in either order or together. The minimum write occupancy is 3 cycles: handshake, commit, response.
- Read channel:
  - arready = !rvalid.
  - At the ar handshake edge, rdata is captured from the decoded register and rvalid rises (latency 1).
  - status_register and data_o_register are sampled at that edge.
  - Offsets 0x00–0x18 return rresp = OKAY. Offset 0x1C returns rdata=0, rresp=SLVERR.
  - rdata and rresp hold stable while rvalid=1 && !rready. rvalid drops at the edge after rready.
- Address decode: awaddr/araddr bits [1:0] and any bits above [4:2] are ignored.
- Simultaneous read and write:
  - The channels are independent.
  - A read whose capture edge equals a commit edge to the same register returns the pre-write value.
- Command register:
  - cmd_register holds its value until overwritten. The host must write CMD_NOP explicitly to end a command.
  - A CMD_RESET value stays asserted toward the downstream block until the host rewrites the register.
  - This block itself is never reset by the cmd value.
- No combinational path from any AXI input to any AXI output, except ready signals derived from internal state only.

Decomposition:
- AXI_package gains:
  - register offset constants REG_OFF_DATA_IN=0, REG_OFF_ADDRESS=1, REG_OFF_START_CC=2, REG_OFF_END_CC=3, REG_OFF_CMD=4, REG_OFF_STATUS=5, REG_OFF_DATA_O=6 (word index);
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
- It reuses the existing REG_WIDTH, CMD_* and STATUS_* constants.
- Byte-merge is a package function. No sub-module is needed; the read and write paths stay in one module.

Test Plan:
1. Reset check: reset, then read 0x10 -> rdata=CMD_NOP (0), rresp=0; read 0x00 -> 0; awready=wready=arready=1.
2. Write with AW before W:
   - AW 0x04 in cycle 0; W 0xDEADBEEF, wstrb=4'hF in cycle 2.
   - Required: address_register=0xDEADBEEF after the commit edge; bvalid=1 with bresp=0; the next read of 0x04 returns 0xDEADBEEF.
3. Partial strobe: data_in=0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 -> data_in_register=0x11BB33DD.
4. Read-only and unmapped targets:
   - Write 0x14 -> bresp=2'b10, status unaffected.
   - Read 0x1C -> rdata=0, rresp=2'b10.
   - Read 0x14 with status_register=0x3 -> rdata=0x3.
5. Backpressure: hold bready=0 for 5 cycles after a write, then send a second AW/W.
   - Required: the second pair is buffered (awready/wready drop after their handshakes); the second commit happens only after the first bvalid&&bready; the register values are applied in order.
6. Reset mid-write plus concurrent access:
   - AW accepted, rst pulsed before W -> no register change and bvalid=0.
   - Concurrent write 0x10 := CMD_START and read 0x10 on the same edge -> read returns the old value, cmd_register=CMD_START afterward.
